// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: stage stall/flush, exception/ERET redirect
// and the control-register file read by ID and written by WRCR in MEM.
module pipeline_ctrl #(
  parameter int WORD        = 32,
  parameter int WORD_ADDR_W = 30,
  parameter int IRQ_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             creg_rd_addr,
  output logic [WORD-1:0]        creg_rd_data,
  output logic                   exe_mode,
  output logic                   int_en,
  input  logic [IRQ_W-1:0]       irq,
  input  logic                   ld_hazard,
  input  logic                   mem_busy,
  input  logic                   mem_en,
  input  logic [WORD_ADDR_W-1:0] mem_pc,
  input  logic [1:0]             mem_ctrl_op,
  input  logic [2:0]             mem_exp_code,
  input  logic [4:0]             mem_dst_addr,
  input  logic [WORD-1:0]        mem_out,
  output logic                   if_stall,
  output logic                   id_stall,
  output logic                   ex_stall,
  output logic                   mem_stall,
  output logic                   if_flush,
  output logic                   id_flush,
  output logic                   ex_flush,
  output logic                   mem_flush,
  output logic [WORD_ADDR_W-1:0] new_pc
);

  localparam logic [1:0] OP_WRCR = 2'd1;
  localparam logic [1:0] OP_ERET = 2'd2;

  localparam logic [2:0] EXP_NONE = 3'd0;
  localparam logic [2:0] EXP_INT  = 3'd1;

  localparam logic [4:0] CR_STATUS = 5'd0;
  localparam logic [4:0] CR_PRE    = 5'd1;
  localparam logic [4:0] CR_EPC    = 5'd2;
  localparam logic [4:0] CR_VEC    = 5'd3;
  localparam logic [4:0] CR_CAUSE  = 5'd4;
  localparam logic [4:0] CR_MASK   = 5'd5;
  localparam logic [4:0] CR_IRQ    = 5'd6;

  logic                   exe_mode_q, exe_mode_d;
  logic                   int_en_q, int_en_d;
  logic [1:0]             pre_status_q, pre_status_d;
  logic [WORD_ADDR_W-1:0] epc_q, epc_d;
  logic [WORD_ADDR_W-1:0] exp_vec_q, exp_vec_d;
  logic [2:0]             cause_q, cause_d;
  logic [IRQ_W-1:0]       int_mask_q, int_mask_d;

  logic       busy;
  logic       irq_pend;
  logic [2:0] code;
  logic       commit;
  logic       exc_ev;
  logic       eret_ev;
  logic       wrcr_ev;
  logic       redirect;
  logic       unused_bits;

  assign unused_bits = ^mem_out;

  // Interrupt outranks whatever exception the MEM instruction carries.
  always_comb begin
    busy     = mem_busy;
    irq_pend = int_en_q & (|(irq & ~int_mask_q)) & mem_en;
    if (irq_pend) begin
      code = EXP_INT;
    end else if (mem_en) begin
      code = mem_exp_code;
    end else begin
      code = EXP_NONE;
    end
    commit  = mem_en & ~busy & ~reset;
    exc_ev  = commit & (code != EXP_NONE);
    eret_ev = commit & (code == EXP_NONE)
            & (mem_ctrl_op == OP_ERET);
    wrcr_ev = commit & (code == EXP_NONE)
            & (mem_ctrl_op == OP_WRCR) & ~exe_mode_q;
    redirect = exc_ev | eret_ev;
  end

  always_comb begin
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    new_pc    = '0;
    if (!reset) begin
      if_stall  = busy | ld_hazard;
      id_stall  = busy;
      ex_stall  = busy;
      mem_stall = busy;
      if_flush  = redirect;
      id_flush  = redirect | (ld_hazard & ~busy);
      ex_flush  = redirect;
      mem_flush = redirect;
      if (exc_ev) begin
        new_pc = exp_vec_q;
      end else if (eret_ev) begin
        new_pc = epc_q;
      end
    end
  end

  always_comb begin
    exe_mode_d   = exe_mode_q;
    int_en_d     = int_en_q;
    pre_status_d = pre_status_q;
    epc_d        = epc_q;
    exp_vec_d    = exp_vec_q;
    cause_d      = cause_q;
    int_mask_d   = int_mask_q;
    unique case (1'b1)
      exc_ev: begin
        pre_status_d = {int_en_q, exe_mode_q};
        epc_d        = mem_pc;
        cause_d      = code;
        exe_mode_d   = 1'b0;
        int_en_d     = 1'b0;
      end
      eret_ev: begin
        {int_en_d, exe_mode_d} = pre_status_q;
      end
      wrcr_ev: begin
        case (mem_dst_addr)
          CR_STATUS: {int_en_d, exe_mode_d} = mem_out[1:0];
          CR_PRE:    pre_status_d = mem_out[1:0];
          CR_EPC:    epc_d        = mem_out[WORD_ADDR_W-1:0];
          CR_VEC:    exp_vec_d    = mem_out[WORD_ADDR_W-1:0];
          CR_CAUSE:  cause_d      = mem_out[2:0];
          CR_MASK:   int_mask_d   = mem_out[IRQ_W-1:0];
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exe_mode_q   <= 1'b0;
      int_en_q     <= 1'b0;
      pre_status_q <= '0;
      epc_q        <= '0;
      exp_vec_q    <= '0;
      cause_q      <= '0;
      int_mask_q   <= '1;
    end else begin
      exe_mode_q   <= exe_mode_d;
      int_en_q     <= int_en_d;
      pre_status_q <= pre_status_d;
      epc_q        <= epc_d;
      exp_vec_q    <= exp_vec_d;
      cause_q      <= cause_d;
      int_mask_q   <= int_mask_d;
    end
  end

  // Reads see registered state only; a WRCR shows up the cycle after.
  always_comb begin
    creg_rd_data = '0;
    case (creg_rd_addr)
      CR_STATUS: creg_rd_data[1:0] = {int_en_q, exe_mode_q};
      CR_PRE:    creg_rd_data[1:0] = pre_status_q;
      CR_EPC:    creg_rd_data[WORD_ADDR_W-1:0] = epc_q;
      CR_VEC:    creg_rd_data[WORD_ADDR_W-1:0] = exp_vec_q;
      CR_CAUSE:  creg_rd_data[2:0] = cause_q;
      CR_MASK:   creg_rd_data[IRQ_W-1:0] = int_mask_q;
      CR_IRQ:    creg_rd_data[IRQ_W-1:0] = irq;
      default: ;
    endcase
  end

  assign exe_mode = exe_mode_q;
  assign int_en   = int_en_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central pipeline controller for the five-stage core (IF/ID/EX/MEM/WB). Generates per-stage stall/flush, the redirect PC for exceptions and ERET, and holds the control registers (CREGs) that stage_ID reads via creg_rd_addr/creg_rd_data and exe_mode. It commits exceptions, interrupts and WRCR/ERET at the MEM stage.

Parameters:
WORD, 32, data width
WORD_ADDR_W, 30, word address width
IRQ_W, 8, external interrupt lines

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
creg_rd_addr  in  5  CREG read address from ID
creg_rd_data  out  WORD  CREG read data, combinational
exe_mode  out  1  0=kernel, 1=user
int_en  out  1  global interrupt enable
irq  in  IRQ_W  level interrupt requests
ld_hazard  in  1  load-use hazard from ID
mem_busy  in  1  bus access in progress
mem_en  in  1  MEM-stage instruction valid
mem_pc  in  WORD_ADDR_W  PC of MEM-stage instruction
mem_ctrl_op  in  2  0=NOP, 1=WRCR, 2=ERET
mem_exp_code  in  3  0=none,2=UNDEF,3=OVF,4=MISALIGN,5=TRAP,6=PRV_VIO
mem_dst_addr  in  5  CREG address for WRCR
mem_out  in  WORD  WRCR write data
if_stall, id_stall, ex_stall, mem_stall  out  1 each  stage stalls
if_flush, id_flush, ex_flush, mem_flush  out  1 each  stage flushes
new_pc  out  WORD_ADDR_W  redirect target, valid while if_flush=1

Behaviour:
- CREG map: 0 STATUS {int_en,exe_mode}; 1 PRE_STATUS; 2 EPC; 3 EXP_VECTOR; 4 CAUSE {exp_code[2:0]}; 5 INT_MASK (1=masked); 6 IRQ (read-only, live irq); other addresses read 0.
- Reset (sync, highest priority): exe_mode=0, int_en=0, PRE_STATUS=0, EPC=0, EXP_VECTOR=0, CAUSE=0, INT_MASK=all 1s; all stall/flush=0; new_pc=0. Reset mid-exception discards the commit.
- Stall: busy=mem_busy. id/ex/mem_stall=busy. if_stall=busy|ld_hazard.
- Load hazard: id_flush=ld_hazard (bubble into EX) when no commit event is active.
- Interrupt pending: int_en & |(irq & ~INT_MASK) & mem_en. Treated as exp_code 1 (EXT_INT) on the MEM instruction, with priority over mem_exp_code.
- Effective code: EXT_INT if interrupt pending; else mem_exp_code if mem_en; else 0.
- Commit requires mem_en & ~busy. No commit and no flush while busy.
- Exception (code≠0), combinational in the commit cycle:
  - All four flushes=1; new_pc=EXP_VECTOR.
  - At the next edge: PRE_STATUS←STATUS, EPC←mem_pc, CAUSE←code, exe_mode←0, int_en←0.
- ERET (ctrl_op=2, code=0):
  - All four flushes=1; new_pc=EPC.
  - At the next edge: STATUS←PRE_STATUS.
- WRCR (ctrl_op=1, code=0, exe_mode=0): at the next edge, CREG[mem_dst_addr]←mem_out (writable regs only). No flush. WRCR in user mode is ignored (ID raises PRV_VIO).
- Flush pulses last exactly one cycle per commit. The flushed MEM slot makes mem_en=0 next cycle, so there is no double commit.
- ld_hazard during a commit: flush wins; if_stall stays ld_hazard|busy.
- WRCR to STATUS/INT_MASK affects interrupt pending from the following cycle. creg_rd_data shows the old value in the write cycle (no bypass).
- Latency: redirect is combinational (0 cycles) from MEM inputs; CREG update takes 1 edge.

Test Plan:
- Reset held 2 cycles → exe_mode=0, int_en=0, INT_MASK=8'hFF, all stall/flush=0; creg_rd_addr=5 reads 32'h000000FF.
- WRCR: mem_en=1, ctrl_op=1, dst=3, mem_out=32'h100 → next cycle creg read 3 = 32'h100; no flush.
- Exception: mem_en=1, mem_exp_code=3, mem_pc=30'h250 → same cycle all flushes=1 and new_pc=30'h100; next cycle EPC=30'h250, CAUSE=3, exe_mode=0.
- Interrupt: STATUS int_en=1, INT_MASK=8'hFE, irq=8'h01, mem_en=1 → flush, CAUSE=1, int_en=0. Then ERET → new_pc=EPC and int_en restored to 1.
- Busy: mem_busy=1 with mem_exp_code=2 → all stalls=1, no flush, no CREG change until mem_busy=0, then the commit occurs.
- Hazard: ld_hazard=1 alone → if_stall=1, id_flush=1, other outputs 0. ld_hazard with ERET in the same cycle → all flushes=1, new_pc=EPC.
